// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core
//   Multi-cycle RV32I-subset processor with one unified instruction/data
//   memory port. A control FSM steps each instruction through
//   FETCH/DECODE and one or more execute states. The core halts on
//   ecall/ebreak (done) or on an unsupported encoding (illegal).
//
// Parameters
//   XLEN     - register/datapath width (>= 32), immediates sign-extended to it
//   RESET_PC - PC loaded at reset
//   ADDR_W   - memory address width (low ADDR_W bits of the computed address)
//
// Ports
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   mem_req   - memory request, held until mem_ready
//   mem_we    - write strobe, valid with mem_req
//   mem_addr  - byte address
//   mem_wdata - store data
//   mem_rdata - read data, sampled when mem_ready=1
//   mem_ready - completes the current request
//   done      - halted by ecall/ebreak
//   illegal   - halted on an unsupported instruction
//
// Build option
//   RISCV_MUL_EN - when defined, R-type mul (funct7=0000001, funct3=000)
//                  is legal and EXEC produces the low XLEN bits of A*B.

module riscv_multicycle_core #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic              done,
    output logic              illegal
);

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADDR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_HALT_DONE,
        S_HALT_ILL
    } state_t;

    state_t state, state_next, decode_next;

    logic [XLEN-1:0] pc, old_pc, a, b, alu_out, mdr;
    logic [31:0]     ir;
    logic [XLEN-1:0] regs [32];

    // Instruction fields
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-31){v[31]}}, v[30:0]};
    endfunction

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    assign imm_i = sext32({{20{ir[31]}}, ir[31:20]});
    assign imm_s = sext32({{20{ir[31]}}, ir[31:25], ir[11:7]});
    assign imm_b = sext32({{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0});
    assign imm_j = sext32({{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0});
    assign imm_u = sext32({ir[31:12], 12'b0});

    logic is_mul;
`ifdef RISCV_MUL_EN
    assign is_mul = (opcode == OPC_REG) && (funct7 == 7'b0000001) && (funct3 == 3'b000);
`else
    assign is_mul = 1'b0;
`endif

    // funct3 values shared by the supported register and immediate ALU ops
    logic alu_f3_ok, r_legal, br_legal;
    assign alu_f3_ok = (funct3 != 3'b001) && (funct3 != 3'b101);
    assign r_legal   = ((funct7 == 7'b0000000) && alu_f3_ok)
                     || ((funct7 == 7'b0100000) && (funct3 == 3'b000))
                     || is_mul;
    assign br_legal  = (funct3 == 3'b000) || (funct3 == 3'b001)
                     || (funct3 == 3'b100) || (funct3 == 3'b101);

    // ALU used in EXEC
    logic [XLEN-1:0] op2, alu_res;
    assign op2 = (opcode == OPC_REG) ? b : imm_i;

    always_comb begin
        alu_res = '0;
        unique case (funct3)
            3'b000: begin
                if ((opcode == OPC_REG) && funct7[5]) alu_res = a - op2;
                else                                  alu_res = a + op2;
`ifdef RISCV_MUL_EN
                if (is_mul) alu_res = a * b;
`endif
            end
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(op2)};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, a < op2};
            3'b100:  alu_res = a ^ op2;
            3'b110:  alu_res = a | op2;
            3'b111:  alu_res = a & op2;
            default: alu_res = '0;
        endcase
    end

    logic take_branch;
    always_comb begin
        unique case (funct3)
            3'b000:  take_branch = (a == b);
            3'b001:  take_branch = (a != b);
            3'b100:  take_branch = $signed(a) < $signed(b);
            3'b101:  take_branch = $signed(a) >= $signed(b);
            default: take_branch = 1'b0;
        endcase
    end

    logic [XLEN-1:0] link, jalr_sum;
    assign link     = old_pc + XLEN'(4);
    assign jalr_sum = a + imm_i;

    // Dispatch out of DECODE
    always_comb begin
        decode_next = S_HALT_ILL;
        unique case (opcode)
            OPC_REG:    if (r_legal)   decode_next = S_EXEC;
            OPC_IMM:    if (alu_f3_ok) decode_next = S_EXEC;
            OPC_LOAD,
            OPC_STORE:  if (funct3 == 3'b010) decode_next = S_MEMADDR;
            OPC_BRANCH: if (br_legal)  decode_next = S_BRANCH;
            OPC_JAL:    decode_next = S_JAL;
            OPC_JALR:   if (funct3 == 3'b000) decode_next = S_JALR;
            OPC_LUI:    decode_next = S_LUI;
            OPC_SYSTEM: if ((ir == 32'h0000_0073) || (ir == 32'h0010_0073))
                            decode_next = S_HALT_DONE;
            default:    decode_next = S_HALT_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:     if (mem_ready) state_next = S_DECODE;
            S_DECODE:    state_next = decode_next;
            S_EXEC:      state_next = S_ALUWB;
            S_MEMADDR:   state_next = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   if (mem_ready) state_next = S_MEMWB;
            S_MEMWRITE:  if (mem_ready) state_next = S_FETCH;
            S_ALUWB,
            S_MEMWB,
            S_BRANCH,
            S_JAL,
            S_JALR,
            S_LUI:       state_next = S_FETCH;
            S_HALT_DONE,
            S_HALT_ILL:  state_next = state;
            default:     state_next = S_FETCH;
        endcase
    end

    // Register-file write port
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;
    always_comb begin
        rf_we = 1'b0;
        rf_wd = alu_out;
        unique case (state)
            S_ALUWB:        rf_we = 1'b1;
            S_MEMWB:        begin rf_we = 1'b1; rf_wd = mdr;   end
            S_JAL, S_JALR:  begin rf_we = 1'b1; rf_wd = link;  end
            S_LUI:          begin rf_we = 1'b1; rf_wd = imm_u; end
            default:        rf_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: if (mem_ready) begin
                    ir     <= mem_rdata[31:0];
                    old_pc <= pc;
                    pc     <= pc + XLEN'(4);
                end
                S_DECODE: begin
                    a       <= regs[rs1];
                    b       <= regs[rs2];
                    alu_out <= old_pc + imm_b;
                end
                S_EXEC:    alu_out <= alu_res;
                S_MEMADDR: alu_out <= a + ((opcode == OPC_STORE) ? imm_s : imm_i);
                S_MEMREAD: if (mem_ready) mdr <= mem_rdata;
                S_BRANCH:  if (take_branch) pc <= alu_out;
                S_JAL:     pc <= old_pc + imm_j;
                S_JALR:    pc <= {jalr_sum[XLEN-1:1], 1'b0};
                default:   ;
            endcase
            if (rf_we && (rd != 5'd0)) regs[rd] <= rf_wd;
        end
    end

    // Request outputs are gated by rst so an in-flight access drops
    // immediately when reset asserts, not at the next clock edge.
    assign mem_req   = rst && ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE));
    assign mem_we    = rst && (state == S_MEMWRITE);
    assign mem_addr  = (state == S_FETCH) ? pc[ADDR_W-1:0] : alu_out[ADDR_W-1:0];
    assign mem_wdata = b;
    assign done      = (state == S_HALT_DONE);
    assign illegal   = (state == S_HALT_ILL);

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// tb_riscv_multicycle_core
//   Bench for riscv_multicycle_core. A behavioural memory answers requests
//   after a programmable number of wait cycles. Every program pushes its
//   expected bus trace (fetch addresses, load addresses, store addr/data)
//   onto a scoreboard queue; each completed access is popped and compared.

module tb_riscv_multicycle_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ready, done, illegal;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic        model_ready    = 1'b0;
    logic        spurious_ready = 1'b0;
    logic        spurious       = 1'b0;
    assign mem_ready = model_ready | spurious_ready;

    always #5 clk = ~clk;

    riscv_multicycle_core #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .done      (done),
        .illegal   (illegal)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [31:0] mem [256];
    int unsigned wait_cycles = 0;
    logic [31:0] load_pc;

    // ---------------- memory model + scoreboard ----------------
    int unsigned cnt = 0;
    logic        lat_we, st_we;
    logic [31:0] lat_addr, lat_wdata, st_addr, st_wdata;
    acc_t        mon_e;

    always @(negedge clk) begin
        if (!spurious) begin
            if (model_ready && rst) begin
                // the access completed at the preceding rising edge
                check("acc_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("acc_we", 32'(lat_we), 32'(mon_e.we));
                    check("acc_addr", lat_addr, mon_e.addr);
                    if (mon_e.we) check("acc_wdata", lat_wdata, mon_e.data);
                end
                if (lat_we) mem[lat_addr[9:2]] = lat_wdata;
                cnt = 0;
            end
            model_ready = 1'b0;
            if (rst && mem_req) begin
                if (cnt == 0) begin
                    st_addr = mem_addr; st_we = mem_we; st_wdata = mem_wdata;
                end else begin
                    check("stable_addr", mem_addr, st_addr);
                    check("stable_we", 32'(mem_we), 32'(st_we));
                    if (st_we) check("stable_wdata", mem_wdata, st_wdata);
                end
                if (cnt == wait_cycles) begin
                    model_ready = 1'b1;
                    mem_rdata   = mem[mem_addr[9:2]];
                    lat_we      = mem_we;
                    lat_addr    = mem_addr;
                    lat_wdata   = mem_wdata;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] r_t(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_t(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
        logic [31:0] v = imm;
        return {v[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return i_t(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int off, input int rs1);
        logic [31:0] v = off;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int off, input int rs1);
        return i_t(off, rs1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int off);
        logic [31:0] v = off;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int off);
        logic [31:0] v = off;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction
    function automatic logic [31:0] lui(input int rd, input int imm20);
        logic [31:0] v = imm20;
        return {v[19:0], 5'(rd), 7'b0110111};
    endfunction
    localparam logic [31:0] ECALL = 32'h0000_0073;

    // ---------------- program helpers ----------------
    task automatic new_prog();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        exp_q.delete();
        load_pc = '0;
    endtask
    task automatic put(input logic [31:0] addr, input logic [31:0] instr);
        mem[addr[9:2]] = instr;
    endtask
    task automatic exp_acc(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{we: we, addr: a, data: d});
    endtask
    task automatic emit(input logic [31:0] instr);
        put(load_pc, instr);
        exp_acc(1'b0, load_pc, '0);
        load_pc += 4;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_done_ill", {30'b0, done, illegal}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_to_halt(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(done || illegal) && cyc < max_cyc);
        check("halt_reached", 32'(done | illegal), 32'd1);
    endtask

    task automatic finish_prog(input string name, input int cyc, input int exp_cyc,
                               input logic exp_done, input logic exp_ill);
        check({name, "_cycles"}, cyc, exp_cyc);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
        repeat (4) @(negedge clk);
        check({name, "_halt_held"}, {30'b0, done, illegal}, {30'b0, exp_done, exp_ill});
        check({name, "_halt_noreq"}, 32'(mem_req), 32'd0);
        check({name, "_trace_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int          cyc;
        logic [31:0] ins [17];
        int          rdv [17];
        logic [31:0] val [17];
        logic        found;

        // P1: basic add + ecall timing, zero-wait
        new_prog();
        wait_cycles = 0;
        emit(addi(1, 0, 5));
        emit(addi(2, 0, -3));
        emit(r_t(7'h00, 2, 1, 3'b000, 3));
        emit(ECALL);
        apply_reset();
        run_to_halt(100, cyc);
        check("p1_cycles", cyc, 15);
        check("p1_done", 32'(done), 32'd1);
        check("p1_illegal", 32'(illegal), 32'd0);
        // mem_ready with no request must not disturb a halted core
        spurious = 1'b1;
        spurious_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_noreq", 32'(mem_req), 32'd0);
        check("spurious_done", 32'(done), 32'd1);
        spurious_ready = 1'b0;
        @(negedge clk);
        spurious = 1'b0;
        check("p1_trace_left", exp_q.size(), 32'd0);

        // P2: ALU coverage, each result stored to 0x100+4k
        ins[0]  = r_t(7'h00, 2, 1, 3'b000, 3);  rdv[0]  = 3;  val[0]  = 32'd2;
        ins[1]  = r_t(7'h20, 2, 1, 3'b000, 4);  rdv[1]  = 4;  val[1]  = 32'd8;
        ins[2]  = r_t(7'h00, 2, 1, 3'b111, 5);  rdv[2]  = 5;  val[2]  = 32'd5;
        ins[3]  = r_t(7'h00, 2, 1, 3'b110, 6);  rdv[3]  = 6;  val[3]  = 32'hFFFF_FFFD;
        ins[4]  = r_t(7'h00, 2, 1, 3'b100, 7);  rdv[4]  = 7;  val[4]  = 32'hFFFF_FFF8;
        ins[5]  = r_t(7'h00, 2, 1, 3'b010, 8);  rdv[5]  = 8;  val[5]  = 32'd0;
        ins[6]  = r_t(7'h00, 1, 2, 3'b010, 9);  rdv[6]  = 9;  val[6]  = 32'd1;
        ins[7]  = r_t(7'h00, 2, 1, 3'b011, 10); rdv[7]  = 10; val[7]  = 32'd1;
        ins[8]  = r_t(7'h00, 1, 2, 3'b011, 19); rdv[8]  = 19; val[8]  = 32'd0;
        ins[9]  = i_t(32'hF0, 2, 3'b111, 11, 7'b0010011); rdv[9]  = 11; val[9]  = 32'h0000_00F0;
        ins[10] = i_t(-16, 1, 3'b110, 12, 7'b0010011);    rdv[10] = 12; val[10] = 32'hFFFF_FFF5;
        ins[11] = i_t(32'h7FF, 1, 3'b100, 13, 7'b0010011); rdv[11] = 13; val[11] = 32'h0000_07FA;
        ins[12] = i_t(-2, 2, 3'b010, 14, 7'b0010011);     rdv[12] = 14; val[12] = 32'd1;
        ins[13] = i_t(-1, 1, 3'b011, 15, 7'b0010011);     rdv[13] = 15; val[13] = 32'd1;
        ins[14] = i_t(-2, 1, 3'b010, 16, 7'b0010011);     rdv[14] = 16; val[14] = 32'd0;
        ins[15] = addi(18, 2, -2048);                     rdv[15] = 18; val[15] = 32'hFFFF_F7FD;
        ins[16] = lui(17, 32'hABCDE);                     rdv[16] = 17; val[16] = 32'hABCD_E000;
        new_prog();
        emit(addi(1, 0, 5));
        emit(addi(2, 0, -3));
        for (int k = 0; k < 17; k++) begin
            emit(ins[k]);
            emit(sw(rdv[k], 32'h100 + 4 * k, 0));
            exp_acc(1'b1, 32'h100 + 4 * k, val[k]);
        end
        emit(ECALL);
        apply_reset();
        run_to_halt(400, cyc);
        finish_prog("alu", cyc, 146, 1'b1, 1'b0);

        // P3: sw/lw with 3 wait cycles per access
        new_prog();
        wait_cycles = 3;
        emit(addi(1, 0, 5));
        emit(addi(2, 0, -3));
        emit(r_t(7'h00, 2, 1, 3'b000, 3));
        emit(sw(3, 8, 0));
        exp_acc(1'b1, 32'd8, 32'd2);
        emit(lw(4, 8, 0));
        exp_acc(1'b0, 32'd8, '0);
        emit(sw(4, 32'h104, 0));
        exp_acc(1'b1, 32'h104, 32'd2);
        emit(ECALL);
        apply_reset();
        run_to_halt(300, cyc);
        finish_prog("waitmem", cyc, 58, 1'b1, 1'b0);

        // P4: branches, zero-wait
        new_prog();
        wait_cycles = 0;
        put(32'd0,  addi(1, 0, -1));
        put(32'd4,  addi(2, 0, 1));
        put(32'd8,  br(3'b000, 0, 0, 8));
        put(32'd12, addi(5, 0, 7));
        put(32'd16, br(3'b001, 0, 0, 8));
        put(32'd20, addi(6, 0, 9));
        put(32'd24, br(3'b100, 1, 2, 8));
        put(32'd28, addi(7, 0, 3));
        put(32'd32, br(3'b101, 1, 2, 8));
        put(32'd36, addi(8, 0, 4));
        put(32'd40, br(3'b101, 2, 1, 8));
        put(32'd44, addi(9, 0, 1));
        for (int k = 0; k < 5; k++) put(32'd48 + 4 * k, sw(5 + k, 32'h100 + 4 * k, 0));
        put(32'd68, ECALL);
        foreach (ins[k]) ins[k] = '0;
        ins[0] = 0;  ins[1] = 4;  ins[2] = 8;  ins[3] = 16; ins[4] = 20;
        ins[5] = 24; ins[6] = 32; ins[7] = 36; ins[8] = 40;
        for (int k = 0; k < 9; k++) exp_acc(1'b0, ins[k], '0);
        val[0] = 0; val[1] = 9; val[2] = 0; val[3] = 4; val[4] = 0;
        for (int k = 0; k < 5; k++) begin
            exp_acc(1'b0, 32'd48 + 4 * k, '0);
            exp_acc(1'b1, 32'h100 + 4 * k, val[k]);
        end
        exp_acc(1'b0, 32'd68, '0);
        apply_reset();
        run_to_halt(200, cyc);
        finish_prog("branch", cyc, 54, 1'b1, 1'b0);

        // P5: jal / jalr (LSB of target cleared) / x0 writes dropped
        new_prog();
        put(32'h00, addi(0, 0, 5));
        put(32'h04, addi(10, 0, 1));
        put(32'h08, addi(11, 0, 2));
        put(32'h0C, addi(12, 0, 3));
        put(32'h10, jal(1, 12));
        put(32'h14, sw(1, 32'h100, 0));
        put(32'h18, br(3'b000, 0, 0, 12));
        put(32'h1C, i_t(1, 1, 3'b000, 3, 7'b1100111));
        put(32'h24, sw(3, 32'h104, 0));
        put(32'h28, sw(0, 32'h108, 0));
        put(32'h2C, ECALL);
        exp_acc(1'b0, 32'h00, '0); exp_acc(1'b0, 32'h04, '0);
        exp_acc(1'b0, 32'h08, '0); exp_acc(1'b0, 32'h0C, '0);
        exp_acc(1'b0, 32'h10, '0); exp_acc(1'b0, 32'h1C, '0);
        exp_acc(1'b0, 32'h14, '0); exp_acc(1'b1, 32'h100, 32'h14);
        exp_acc(1'b0, 32'h18, '0); exp_acc(1'b0, 32'h24, '0);
        exp_acc(1'b1, 32'h104, 32'h20);
        exp_acc(1'b0, 32'h28, '0); exp_acc(1'b1, 32'h108, 32'h0);
        exp_acc(1'b0, 32'h2C, '0);
        apply_reset();
        run_to_halt(200, cyc);
        finish_prog("jump", cyc, 40, 1'b1, 1'b0);

        // P6: mul 7*6
        new_prog();
        emit(addi(1, 0, 7));
        emit(addi(2, 0, 6));
        emit(r_t(7'h01, 2, 1, 3'b000, 5));
`ifdef RISCV_MUL_EN
        emit(sw(5, 32'h100, 0));
        exp_acc(1'b1, 32'h100, 32'd42);
        emit(ECALL);
        apply_reset();
        run_to_halt(200, cyc);
        finish_prog("mul", cyc, 19, 1'b1, 1'b0);
`else
        put(load_pc, sw(5, 32'h100, 0));
        put(load_pc + 4, ECALL);
        apply_reset();
        run_to_halt(200, cyc);
        finish_prog("mul", cyc, 11, 1'b0, 1'b1);
`endif

        // P7: unsupported encoding (slli)
        new_prog();
        emit(addi(1, 0, 1));
        emit(i_t(1, 1, 3'b001, 2, 7'b0010011));
        put(load_pc, ECALL);
        apply_reset();
        run_to_halt(100, cyc);
        finish_prog("slli", cyc, 7, 1'b0, 1'b1);

        // P8: reset during a waited store, then restart from RESET_PC
        new_prog();
        wait_cycles = 3;
        emit(addi(1, 0, 5));
        emit(sw(1, 32'h100, 0));
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mem_req && mem_we) found = 1'b1;
        end
        check("sw_request_seen", 32'(found), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("sw_wait_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("async_drop_req", 32'(mem_req), 32'd0);
        check("async_drop_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("abort_trace_left", exp_q.size(), 32'd0);
        check("abort_no_write", mem[32'h100 >> 2], 32'hDEAD_BEEF);
        exp_q.delete();
        load_pc = '0;
        wait_cycles = 0;
        for (int r = 1; r < 32; r++) begin
            emit(sw(r, 32'h100 + 4 * (r - 1), 0));
            exp_acc(1'b1, 32'h100 + 4 * (r - 1), 32'h0);
        end
        emit(ECALL);
        apply_reset();
        run_to_halt(400, cyc);
        finish_prog("post_reset", cyc, 127, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
